fp_addsub_pipe: RTL and testbench
=================================

# fp_addsub_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshaking on both sides. It is the successor of the single-cycle float adder. It adds configurable exponent and mantissa widths, a subtract mode, round-to-nearest-even, special-value handling and exception flags. It sits between an operand-issue unit and a result consumer, and accepts one operation per cycle when unstalled.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored mantissa field width (≥4); word width W = 1+EXP_W+MAN_W
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair present
- in_ready  output  1  pipeline can accept this cycle
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_sub  input  1  0: A+B, 1: A−B (B sign inverted at stage 1)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_res  output  W  result
- out_flags  output  4  {invalid, overflow, underflow, inexact}

## Operation
- Three registered stages (S1, S2, S3), each with a valid bit; out_valid = S3 valid, out_res/out_flags = S3 registers.
- Global advance: adv = !out_valid || out_ready; in_ready = adv. When adv=0 every stage holds. Bubbles are not squeezed out, and the pipeline does not compact.
- Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
- S1 (unpack/align):
  - Exponent 0 is treated as zero and denormals are flushed; stored mantissa is ignored.
  - Prepend hidden 1 and swap so the larger magnitude (exp, then mantissa) is operand L.
  - Right-shift the smaller operand by the exponent difference into MAN_W+4 bits (hidden, MAN_W, guard, round) plus sticky, which is the OR of the bits shifted out.
  - A shift ≥ MAN_W+3 leaves only sticky.
- S2 (add/normalise):
  - Same effective sign: add, and on carry-out shift right 1 (folding into sticky) and increment exp.
  - Different sign: subtract (L ≥ S, so non-negative). Count leading zeros, left-shift to restore the hidden bit, and decrement exp by the shift.
  - Result sign is L's sign.
- S3 (round/pack):
  - Round to nearest, ties to even, using guard/round/sticky. Mantissa overflow from rounding increments exp.
  - Exp ≥ 2^EXP_W−1 gives ±infinity, with overflow=1 and inexact=1.
  - Exp ≤ 0 gives signed zero, with underflow=1 and inexact=1.
  - Inexact=1 whenever any of guard/round/sticky is set.
- Specials, resolved in S1 and carried through unchanged:
  - Any NaN input gives canonical NaN (exp all ones, mantissa MSB 1, others 0, sign 0).
  - +inf + −inf (after sub inversion) gives canonical NaN with invalid=1.
  - A single infinity gives that infinity, with flags 0.
- Zero results:
  - Exact cancellation (x−x) gives +0.
  - (−0)+(−0) gives −0.
  - Zero plus nonzero X gives X exactly.

## Timing
- Latency: 3 cycles from input transfer to out_valid, with no stall.
- Throughput: 1 per cycle while out_ready=1.
- in_ready is a combinational function of out_valid and out_ready only, never of in_valid.
- While out_valid=1 and out_ready=0, out_res/out_flags stay stable and in_ready=0.
- Reset (asynchronous, any cycle, including mid-stall):
  - all stage valid bits clear; out_valid=0; in_ready=1.
  - out_res=0 and out_flags=0.
  - In-flight operations are discarded.
- First accept is allowed on the first edge after rst_n deasserts.
- Simultaneous output accept and input transfer in the same cycle is legal and loses nothing.

## Test plan
- Basic add, EXP_W=8, MAN_W=23: 0x3F800000 + 0x40000000, sub=0 → 0x40400000, flags 0, out_valid exactly 3 cycles after accept.
- Subtract and cancel: 0x40400000 − 0x40400000 → 0x00000000. Then 0x3F800000 − 0x40000000 → 0xBF800000.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000 with inexact=1.
  - 0x3F800000 + 0x33C00000 → 0x3F800001 with inexact=1.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with overflow and inexact set.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000 with invalid=1.
  - 0x7FC00001 + 1.0 → 0x7FC00000.
- Backpressure: stream 8 back-to-back adds with out_ready toggling randomly → results appear in order and none are lost or duplicated. Results are held stable while out_ready=0, and in_ready tracks !out_valid||out_ready.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 operations in flight → out_valid drops immediately. After release, no stale result appears, and the next operation completes in 3 cycles.

Source files
------------

// File: rtl/fp_addsub_pipe_if.sv
// Valid/ready bundle for fp_addsub_pipe: operand-issue side and result side.
// master drives operands and out_ready; slave (the adder) drives the rest.
interface fp_addsub_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_res, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_res, out_flags
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor (unpack/align, add/normalise, round/pack)
// with round-to-nearest-even, flushed denormals and {invalid, overflow, underflow, inexact}.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic             clk,
  input logic             rst_n,
  fp_addsub_pipe_if.slave bus_io
);
  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned FW  = MAN_W + 3;  // hidden, mantissa, guard, round
  localparam int unsigned XW  = MAN_W + 4;  // FW plus sticky
  localparam int unsigned EW  = EXP_W + 2;  // signed working exponent
  localparam int unsigned LZW = $clog2(XW + 1);

  localparam logic [EXP_W-1:0]    ExpOnes  = {EXP_W{1'b1}};
  localparam logic signed [EW-1:0] ExpInf  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW-1:0] ExpZero = '0;
  localparam logic [W-1:0] CanonNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv             = !bus_io.out_valid || bus_io.out_ready;
  assign bus_io.in_ready = adv;

  // ---------------- S1: unpack, specials, swap, align ----------------
  logic             sa, sb, sl;
  logic [EXP_W-1:0] ea, eb, el, es, ediff;
  logic [MAN_W-1:0] fa, fb, fl, fs;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [2*FW-1:0]  sh_wide;
  logic [XW-1:0]    s1_ms_d;
  logic             s1_spec_d;
  logic [W-1:0]     s1_sres_d;
  logic [3:0]       s1_sflg_d;

  logic             s1_v_q, s1_spec_q, s1_sign_q, s1_esub_q;
  logic [W-1:0]     s1_sres_q;
  logic [3:0]       s1_sflg_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [XW-1:0]    s1_ml_q, s1_ms_q;

  always_comb begin
    sa = bus_io.in_a[W-1];
    ea = bus_io.in_a[W-2:MAN_W];
    fa = bus_io.in_a[MAN_W-1:0];
    sb = bus_io.in_b[W-1] ^ bus_io.in_sub;
    eb = bus_io.in_b[W-2:MAN_W];
    fb = bus_io.in_b[MAN_W-1:0];

    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == ExpOnes) && (fa == '0);
    b_inf  = (eb == ExpOnes) && (fb == '0);
    a_nan  = (ea == ExpOnes) && (fa != '0);
    b_nan  = (eb == ExpOnes) && (fb != '0);

    if ({eb, fb} > {ea, fa}) begin
      sl = sb; el = eb; fl = fb; es = ea; fs = fa;
    end else begin
      sl = sa; el = ea; fl = fa; es = eb; fs = fb;
    end
    ediff = el - es;

    sh_wide = '0;
    if (32'(ediff) >= FW) begin
      s1_ms_d = {{FW{1'b0}}, 1'b1};
    end else begin
      // Low half of the wide shift catches every bit pushed past the round position.
      sh_wide = {1'b1, fs, 2'b00, {FW{1'b0}}} >> ediff;
      s1_ms_d = {sh_wide[2*FW-1:FW], |sh_wide[FW-1:0]};
    end

    s1_spec_d = 1'b1;
    s1_sres_d = '0;
    s1_sflg_d = '0;
    if (a_nan || b_nan) begin
      s1_sres_d = CanonNan;
    end else if (a_inf && b_inf && (sa != sb)) begin
      s1_sres_d = CanonNan;
      s1_sflg_d = 4'b1000;
    end else if (a_inf) begin
      s1_sres_d = {sa, ExpOnes, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_sres_d = {sb, ExpOnes, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      s1_sres_d = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      s1_sres_d = {sb, eb, fb};
    end else if (b_zero) begin
      s1_sres_d = bus_io.in_a;
    end else begin
      s1_spec_d = 1'b0;
    end
  end

  // ---------------- S2: add/subtract, normalise ----------------
  logic [XW:0]          sum;
  logic [XW-1:0]        dif, s2_norm_d;
  logic [LZW-1:0]       lzc;
  logic signed [EW-1:0] s2_exp_d;
  logic                 s2_spec_d;
  logic [W-1:0]         s2_sres_d;
  logic [3:0]           s2_sflg_d;

  logic                 s2_v_q, s2_spec_q, s2_sign_q;
  logic [W-1:0]         s2_sres_q;
  logic [3:0]           s2_sflg_q;
  logic signed [EW-1:0] s2_exp_q;
  logic [XW-1:0]        s2_norm_q;

  always_comb begin
    sum = {1'b0, s1_ml_q} + {1'b0, s1_ms_q};
    dif = s1_ml_q - s1_ms_q;
    lzc = '0;
    for (int i = 0; i < XW; i++) begin
      if (dif[i]) lzc = LZW'(XW - 1 - i);
    end

    s2_exp_d  = $signed({2'b00, s1_exp_q});
    s2_norm_d = sum[XW-1:0];
    s2_spec_d = s1_spec_q;
    s2_sres_d = s1_sres_q;
    s2_sflg_d = s1_sflg_q;
    if (!s1_spec_q) begin
      if (s1_esub_q) begin
        if (dif == '0) begin
          s2_spec_d = 1'b1;
          s2_sres_d = '0;
          s2_sflg_d = '0;
        end
        s2_norm_d = dif << lzc;
        s2_exp_d  = s2_exp_d - EW'(lzc);
      end else if (sum[XW]) begin
        s2_norm_d = {sum[XW:2], sum[1] | sum[0]};
        s2_exp_d  = s2_exp_d + EW'(1);
      end
    end
  end

  // ---------------- S3: round, range check, pack ----------------
  logic [MAN_W:0]       mant;
  logic                 g_b, r_b, s_b, rup;
  logic [MAN_W+1:0]     mr;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         s3_res_d;
  logic [3:0]           s3_flg_d;

  logic                 s3_v_q;
  logic [W-1:0]         s3_res_q;
  logic [3:0]           s3_flg_q;

  always_comb begin
    mant  = s2_norm_q[XW-1:3];
    g_b   = s2_norm_q[2];
    r_b   = s2_norm_q[1];
    s_b   = s2_norm_q[0];
    rup   = g_b & (r_b | s_b | mant[0]);
    mr    = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rup};
    exp_r = s2_exp_q + EW'(mr[MAN_W+1]);

    s3_res_d = {s2_sign_q, exp_r[EXP_W-1:0], mr[MAN_W+1] ? {MAN_W{1'b0}} : mr[MAN_W-1:0]};
    s3_flg_d = {3'b000, g_b | r_b | s_b};
    if (s2_spec_q) begin
      s3_res_d = s2_sres_q;
      s3_flg_d = s2_sflg_q;
    end else if (exp_r >= ExpInf) begin
      s3_res_d = {s2_sign_q, ExpOnes, {MAN_W{1'b0}}};
      s3_flg_d = 4'b0101;
    end else if (exp_r <= ExpZero) begin
      s3_res_d = {s2_sign_q, {(W-1){1'b0}}};
      s3_flg_d = 4'b0011;
    end
  end

  // Every stage moves together on adv; stage data only loads behind a valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_esub_q <= 1'b0;
      s1_sres_q <= '0;
      s1_sflg_q <= '0;
      s1_exp_q  <= '0;
      s1_ml_q   <= '0;
      s1_ms_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_spec_q <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_sres_q <= '0;
      s2_sflg_q <= '0;
      s2_exp_q  <= '0;
      s2_norm_q <= '0;
      s3_v_q    <= 1'b0;
      s3_res_q  <= '0;
      s3_flg_q  <= '0;
    end else if (adv) begin
      s1_v_q <= bus_io.in_valid;
      s2_v_q <= s1_v_q;
      s3_v_q <= s2_v_q;
      if (bus_io.in_valid) begin
        s1_spec_q <= s1_spec_d;
        s1_sign_q <= sl;
        s1_esub_q <= sa ^ sb;
        s1_sres_q <= s1_sres_d;
        s1_sflg_q <= s1_sflg_d;
        s1_exp_q  <= el;
        s1_ml_q   <= {1'b1, fl, 3'b000};
        s1_ms_q   <= s1_ms_d;
      end
      if (s1_v_q) begin
        s2_spec_q <= s2_spec_d;
        s2_sign_q <= s1_sign_q;
        s2_sres_q <= s2_sres_d;
        s2_sflg_q <= s2_sflg_d;
        s2_exp_q  <= s2_exp_d;
        s2_norm_q <= s2_norm_d;
      end
      if (s2_v_q) begin
        s3_res_q <= s3_res_d;
        s3_flg_q <= s3_flg_d;
      end
    end
  end

  assign bus_io.out_valid = s3_v_q;
  assign bus_io.out_res   = s3_res_q;
  assign bus_io.out_flags = s3_flg_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe in single-precision format.
module tb_fp_addsub_pipe;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned W     = 32;
  localparam logic [W-1:0] One  = 32'h3F800000;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  fp_addsub_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one operation into an idle pipeline and returns the result and its latency.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] res, output logic [3:0] flg, output int lat);
    @(negedge clk);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_sub    = sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    res = '0;
    flg = '0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.out_valid) begin
      res = bus.out_res;
      flg = bus.out_flags;
    end else begin
      lat = 99;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    n_vec++;
    if (bus.out_res !== '0) begin
      n_bad++; $display("FAIL reset_out_res: got %h expected 0", bus.out_res);
    end
    n_vec++;
    if (bus.out_flags !== 4'b0) begin
      n_bad++; $display("FAIL reset_out_flags: got %b expected 0000", bus.out_flags);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add();
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           lat;
    issue(32'h3F800000, 32'h40000000, 1'b0, res, flg, lat);
    n_vec++;
    if (res !== 32'h40400000) begin
      n_bad++; $display("FAIL basic_res: got %h expected 40400000", res);
    end
    n_vec++;
    if (flg !== 4'b0000) begin
      n_bad++; $display("FAIL basic_flags: got %b expected 0000", flg);
    end
    n_vec++;
    if (lat != 3) begin
      n_bad++; $display("FAIL basic_latency: got %0d expected 3", lat);
    end
  endtask

  // Table-driven: subtraction, rounding, specials, zeros and underflow.
  task automatic test_arith(input string tag, input int n, input vec_t tab [8]);
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           lat;
    for (int i = 0; i < n; i++) begin
      issue(tab[i].a, tab[i].b, tab[i].sub, res, flg, lat);
      n_vec++;
      if (res !== tab[i].res || flg !== tab[i].flg) begin
        n_bad++;
        $display("FAIL %s[%0d]: got %h/%b expected %h/%b", tag, i, res, flg,
                 tab[i].res, tab[i].flg);
      end
    end
  endtask

  task automatic test_sub_cancel();
    vec_t tab [8];
    tab = '{default: '0};
    tab[0] = '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000};
    tab[1] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
    test_arith("sub", 2, tab);
  endtask

  task automatic test_rounding();
    vec_t tab [8];
    tab = '{default: '0};
    tab[0] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    tab[1] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
    tab[2] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
    test_arith("round", 3, tab);
  endtask

  task automatic test_specials();
    vec_t tab [8];
    tab = '{default: '0};
    tab[0] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
    tab[1] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
    tab[2] = '{32'h7FC00001, One,          1'b0, 32'h7FC00000, 4'b0000};
    tab[3] = '{32'hFF800000, One,          1'b0, 32'hFF800000, 4'b0000};
    tab[4] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011};
    test_arith("special", 5, tab);
  endtask

  task automatic test_zeros();
    vec_t tab [8];
    tab = '{default: '0};
    tab[0] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    tab[1] = '{32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 4'b0000};
    tab[2] = '{32'h40400000, 32'h00000001, 1'b0, 32'h40400000, 4'b0000};
    test_arith("zero", 3, tab);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a_tab [8];
    logic [W-1:0] e_tab [8];
    logic [W-1:0] held_res;
    logic         held_v;
    int           tx;
    int           rx;
    int           extra;
    a_tab = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    e_tab = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    held_res = '0;
    held_v   = 1'b0;
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 300 && rx < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 1) == 1);
      bus.in_valid  = (tx < 8);
      if (tx < 8) begin
        bus.in_a   = a_tab[tx];
        bus.in_b   = One;
        bus.in_sub = 1'b0;
      end
      #1;
      n_vec++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        n_bad++;
        $display("FAIL bp_in_ready: got %b expected %b", bus.in_ready,
                 !bus.out_valid || bus.out_ready);
      end
      if (held_v) begin
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_res !== held_res) begin
          n_bad++;
          $display("FAIL bp_hold: got %b/%h expected 1/%h", bus.out_valid, bus.out_res,
                   held_res);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (bus.out_res !== e_tab[rx]) begin
          n_bad++; $display("FAIL bp_result[%0d]: got %h expected %h", rx, bus.out_res, e_tab[rx]);
        end
        rx++;
      end
      held_v   = bus.out_valid && !bus.out_ready;
      held_res = bus.out_res;
      if (bus.in_valid && bus.in_ready) tx++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_vec++;
    if (rx != 8) begin
      n_bad++; $display("FAIL bp_count: got %0d expected 8", rx);
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_bad++; $display("FAIL bp_extra: got %0d expected 0", extra);
    end
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           lat;
    int           stale;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h40400000;
      bus.in_b     = One;
      bus.in_sub   = 1'b0;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_inflight: got %b expected 1", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_async: got valid %b ready %b expected 0/1", bus.out_valid, bus.in_ready);
    end
    n_vec++;
    if (bus.out_res !== '0 || bus.out_flags !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_async_data: got %h/%b expected 0/0000", bus.out_res, bus.out_flags);
    end
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    n_vec++;
    if (stale != 0) begin
      n_bad++; $display("FAIL rst_stale: got %0d expected 0", stale);
    end
    issue(32'h40400000, 32'h3F800000, 1'b1, res, flg, lat);
    n_vec++;
    if (res !== 32'h40000000 || lat != 3) begin
      n_bad++; $display("FAIL rst_next_op: got %h lat %0d expected 40000000 lat 3", res, lat);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_add();
    test_sub_cancel();
    test_rounding();
    test_specials();
    test_zeros();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
